enc_speed_meter: RTL

Measurement scheduler for the encoder path. It consumes the single-cycle rising-edge pulse produced by the encoder edge detector and sequences gated measurement windows. Each window yields a pulse count, which gives speed. A free-running sub-block measures edge-to-edge period for low-speed use. It sits between the edge detector and the motor-control/display logic.

---
 rtl/enc_pkg.sv | 18 +
 rtl/enc_period_meter.sv | 56 +++++
 rtl/enc_speed_meter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// Shared types and constants for the encoder speed-measurement path.
package enc_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GATE = 1'b1
    } state_e;

    localparam int GATE_CYCLES_DFLT = 1000000;
    localparam int CNT_W_DFLT       = 16;
    localparam int PER_W_DFLT       = 24;

    // All-ones value of a w-bit counter, for saturation compares.
    function automatic logic [63:0] sat_max(input int w);
        return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/enc_period_meter.sv
// Free-running edge-to-edge period counter; reports cycles between consecutive enc_pos pulses.
module enc_period_meter
    import enc_pkg::*;
#(
    parameter int PER_W = PER_W_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_pos,
    output logic [PER_W-1:0] period_out,
    output logic             period_valid
);

    localparam logic [PER_W-1:0] PER_MAX = PER_W'(sat_max(PER_W));

    logic [PER_W-1:0] cnt_q, cnt_d;
    logic [PER_W-1:0] period_q, period_d;
    logic             seen_q, seen_d;
    logic             valid_q, valid_d;
    logic [PER_W-1:0] cnt_sat;

    always_comb begin
        // cnt_q+1 saturated is both the next idle count and the reported period
        cnt_sat  = (cnt_q == PER_MAX) ? PER_MAX : cnt_q + PER_W'(1);
        cnt_d    = cnt_sat;
        seen_d   = seen_q;
        period_d = period_q;
        valid_d  = 1'b0;
        if (enc_pos) begin
            cnt_d  = '0;
            seen_d = 1'b1;
            if (seen_q) begin
                period_d = cnt_sat;
                valid_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            seen_q   <= 1'b0;
            period_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            seen_q   <= seen_d;
            period_q <= period_d;
            valid_q  <= valid_d;
        end
    end

    assign period_out   = period_q;
    assign period_valid = valid_q;

endmodule

// File: rtl/enc_speed_meter.sv
// Gated-window encoder pulse counter with continuous mode and abort, plus period meter.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no window open; waits for start (abort blocks it)
// ST_GATE | window open; counts enc_pos, timer counts down to terminal 0
module enc_speed_meter
    import enc_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DFLT,
    parameter int CNT_W       = CNT_W_DFLT,
    parameter int PER_W       = PER_W_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_pos,
    input  logic             start,
    input  logic             cont,
    input  logic             abort,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_out,
    output logic             ovf,
    output logic             cnt_valid,
    output logic [PER_W-1:0] period_out,
    output logic             period_valid
);

    localparam int               TMR_W    = $clog2(GATE_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(sat_max(CNT_W));

    state_e           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             wovf_q, wovf_d;
    logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
    logic             ovf_q, ovf_d;
    logic             cnt_valid_q, cnt_valid_d;

    logic [CNT_W-1:0] acc_inc;
    logic             wovf_inc;

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        acc_d       = acc_q;
        wovf_d      = wovf_q;
        cnt_out_d   = cnt_out_q;
        ovf_d       = ovf_q;
        cnt_valid_d = 1'b0;

        // accumulator value including this cycle's pulse, used only while gating
        acc_inc  = acc_q;
        wovf_inc = wovf_q;
        if (enc_pos) begin
            if (acc_q == CNT_MAX) begin
                wovf_inc = 1'b1;
            end else begin
                acc_inc = acc_q + CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_GATE;
                    tmr_d   = TMR_LOAD;
                    acc_d   = '0;
                    wovf_d  = 1'b0;
                end
            end
            ST_GATE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tmr_q == '0) begin
                    cnt_out_d   = acc_inc;
                    ovf_d       = wovf_inc;
                    cnt_valid_d = 1'b1;
                    if (cont) begin
                        // back-to-back window: next gate cycle starts with the strobe
                        tmr_d  = TMR_LOAD;
                        acc_d  = '0;
                        wovf_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        acc_d   = acc_inc;
                        wovf_d  = wovf_inc;
                    end
                end else begin
                    tmr_d  = tmr_q - TMR_W'(1);
                    acc_d  = acc_inc;
                    wovf_d = wovf_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            acc_q       <= '0;
            wovf_q      <= 1'b0;
            cnt_out_q   <= '0;
            ovf_q       <= 1'b0;
            cnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            acc_q       <= acc_d;
            wovf_q      <= wovf_d;
            cnt_out_q   <= cnt_out_d;
            ovf_q       <= ovf_d;
            cnt_valid_q <= cnt_valid_d;
        end
    end

    assign busy      = (state_q == ST_GATE);
    assign cnt_out   = cnt_out_q;
    assign ovf       = ovf_q;
    assign cnt_valid = cnt_valid_q;

    enc_period_meter #(
        .PER_W (PER_W)
    ) u_period (
        .clk          (clk),
        .rst          (rst),
        .enc_pos      (enc_pos),
        .period_out   (period_out),
        .period_valid (period_valid)
    );

endmodule
